// File: rtl/pred_checker.sv
// In-order prediction check stage: pairs queued predictions with resolved outcomes,
// drives predictor updates and flushes on a miss. Optional macro STAT_SAT_EN saturates the counters.
module pred_checker #(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              init,
   input  logic              pred_valid,
   input  logic [ADDR_W-1:0] pred_addr,
   input  logic              pred_taken,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              upd_valid,
   output logic [ADDR_W-1:0] upd_addr,
   output logic              upd_taken,
   output logic              mispredict,
   output logic              underflow,
   output logic [CNT_W-1:0]  total_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]      CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]      OCC_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

   logic [ADDR_W:0] mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [PW:0]     count;

   logic            push, pop, miss, empty;
   logic [ADDR_W:0] head;

   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef STAT_SAT_EN
      return (v == '1) ? v : v + STAT_ONE;
`else
      return v + STAT_ONE;
`endif
   endfunction

   always_comb begin
      empty      = (count == '0);
      pred_ready = (count != CNT_FULL) && !init;
      head       = mem[rd_ptr];
      push       = pred_valid && pred_ready;
      pop        = res_valid && !empty && !init;
      miss       = pop && (head[0] != res_taken);
   end

   // A miss discards the same-cycle push, so the write is gated with it.
   always_ff @(posedge clk) begin
      if (push && !miss)
         mem[wr_ptr] <= {pred_addr, pred_taken};
   end

   always_ff @(posedge clk) begin
      if (init) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         upd_valid  <= 1'b0;
         upd_addr   <= '0;
         upd_taken  <= 1'b0;
         mispredict <= 1'b0;
         underflow  <= 1'b0;
         total_cnt  <= '0;
         miss_cnt   <= '0;
      end else begin
         upd_valid  <= pop;
         mispredict <= miss;
         if (pop) begin
            upd_addr  <= head[ADDR_W:1];
            upd_taken <= res_taken;
            total_cnt <= bump(total_cnt);
         end
         if (miss)
            miss_cnt <= bump(miss_cnt);
         if (res_valid && empty)
            underflow <= 1'b1;

         if (miss) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
               rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
               count <= count + OCC_ONE;
            else if (pop && !push)
               count <= count - OCC_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pred_checker.sv
// Scoreboard bench for pred_checker: queue-based reference model, directed plan plus random traffic.
module tb_pred_checker;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              init = 1'b1;
   logic              pred_valid = 1'b0;
   logic [ADDR_W-1:0] pred_addr = '0;
   logic              pred_taken = 1'b0;
   logic              pred_ready;
   logic              res_valid = 1'b0;
   logic              res_taken = 1'b0;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_addr;
   logic              upd_taken;
   logic              mispredict;
   logic              underflow;
   logic [CNT_W-1:0]  total_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   pred_checker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .init(init),
      .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
      .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
      .mispredict(mispredict), .underflow(underflow),
      .total_cnt(total_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int taken;
   } entry_t;

   typedef struct {
      int addr;
      int taken;
      int miss;
   } resp_t;

   entry_t mq[$];
   resp_t  sb[$];
   int     m_total = 0;
   int     m_miss  = 0;
   int     m_under = 0;
   int     total = 0;
   int     bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int inc(input int v);
`ifdef STAT_SAT_EN
      return (v >= CMAX) ? CMAX : v + 1;
`else
      return (v + 1) % (CMAX + 1);
`endif
   endfunction

   // Monitor: every update strobe must match the oldest expected response.
   always @(negedge clk) begin
      if (upd_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_upd", 1, 0);
         end else begin
            resp_t r;
            r = sb.pop_front();
            chk("upd_addr", int'(upd_addr), r.addr);
            chk("upd_taken", int'(upd_taken), r.taken);
            chk("mispredict", int'(mispredict), r.miss);
         end
      end else if (mispredict) begin
         chk("mispredict_without_upd", 1, 0);
      end
   end

   // One clock of stimulus; the model advances alongside the DUT.
   task automatic cyc(input bit in, input bit pv, input int pa, input bit pt,
                      input bit rv, input bit rt);
      bit ready, push;
      init       = in;
      pred_valid = pv;
      pred_addr  = ADDR_W'(pa);
      pred_taken = pt;
      res_valid  = rv;
      res_taken  = rt;
      ready = (mq.size() < DEPTH) && !in;
      #1;
      chk("pred_ready", int'(pred_ready), int'(ready));
      if (in) begin
         mq.delete();
         m_total = 0;
         m_miss  = 0;
         m_under = 0;
      end else begin
         push = pv && ready;
         if (rv) begin
            if (mq.size() == 0) begin
               m_under = 1;
            end else begin
               entry_t h;
               resp_t  r;
               h = mq.pop_front();
               r.addr  = h.addr;
               r.taken = rt;
               r.miss  = (h.taken != int'(rt)) ? 1 : 0;
               sb.push_back(r);
               m_total = inc(m_total);
               if (r.miss != 0) begin
                  m_miss = inc(m_miss);
                  mq.delete();
                  push = 1'b0;
               end
            end
         end
         if (push) begin
            entry_t e;
            e.addr  = pa;
            e.taken = int'(pt);
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      chk("total_cnt", int'(total_cnt), m_total);
      chk("miss_cnt", int'(miss_cnt), m_miss);
      chk("underflow", int'(underflow), m_under);
      if (in) begin
         chk("rst_upd_valid", int'(upd_valid), 0);
         chk("rst_upd_addr", int'(upd_addr), 0);
         chk("rst_upd_taken", int'(upd_taken), 0);
         chk("rst_mispredict", int'(mispredict), 0);
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic head_hit(input bit pv, input int pa, input bit pt);
      bit rt;
      rt = (mq.size() > 0) ? mq[0].taken[0] : 1'b0;
      cyc(0, pv, pa, pt, 1, rt);
   endtask

   initial begin
      // reset then fill
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 7, 1, 1, 1);
      cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 1, 2, 0, 0, 0);
      cyc(0, 1, 3, 1, 0, 0);
      cyc(0, 1, 4, 0, 0, 0);
      cyc(0, 1, 5, 1, 0, 0);
      chk("fill_depth", mq.size(), DEPTH);

      // in-order hits
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      idle();

      // miss and flush, then underflow
      cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 1, 2, 1, 0, 0);
      cyc(0, 1, 3, 0, 0, 0);
      cyc(0, 1, 6, 1, 1, 0);
      chk("flush_empty", mq.size(), 0);
      cyc(0, 0, 0, 0, 1, 1);
      idle();

      // simultaneous push/pop at occupancy 2 across pointer wrap
      cyc(0, 1, 2, 1, 0, 0);
      cyc(0, 1, 3, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         head_hit(1, (i + 4) % 8, i[0]);
      head_hit(0, 0, 0);
      head_hit(0, 0, 0);
      idle();

      // mid-operation reset with three queued and underflow set
      cyc(0, 1, 5, 1, 0, 0);
      cyc(0, 1, 6, 0, 0, 0);
      cyc(0, 1, 7, 1, 0, 0);
      cyc(1, 1, 1, 1, 1, 0);
      idle();

      // counter overflow: five hits
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, i, 1, 0, 0);
         cyc(0, 0, 0, 0, 1, 1);
      end
`ifdef STAT_SAT_EN
      chk("ovf_total", int'(total_cnt), 3);
`else
      chk("ovf_total", int'(total_cnt), 1);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bit rv, rt;
         rv = ($urandom_range(0, 2) == 0);
         rt = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].taken[0] : 1'($urandom);
         cyc(($urandom_range(0, 99) == 0), 1'($urandom), int'($urandom_range(0, 7)),
             1'($urandom), rv, rt);
      end
      idle();
      idle();
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pred_checker.md
# pred_checker

Prediction-check stage that sits directly downstream of the one-bit predictor (`onepred`). It queues each issued prediction (address plus predicted direction) in order, pairs it with the branch outcome when that outcome resolves, and drives the predictor's update port. It raises a one-cycle mispredict pulse, flushes younger wrong-path predictions, and keeps running totals of resolved branches and misses.

## Interface
Parameters:
- ADDR_W, 3, width of the predictor table index.
- DEPTH, 4, number of in-flight predictions; must be a power of two, ≥2.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- init  input  1  synchronous active-high reset.
- pred_valid  input  1  the predictor issues a prediction this cycle.
- pred_addr  input  ADDR_W  index of the predicted branch.
- pred_taken  input  1  predicted direction (1 = taken).
- pred_ready  output  1  an issue can be accepted; equals !full && !init.
- res_valid  input  1  the oldest in-flight branch resolves this cycle.
- res_taken  input  1  actual direction of that branch.
- upd_valid  output  1  registered; update strobe to the predictor.
- upd_addr  output  ADDR_W  registered; table index to update.
- upd_taken  output  1  registered; actual direction to write.
- mispredict  output  1  registered one-cycle pulse on a miss.
- underflow  output  1  sticky; a resolution arrived with the queue empty.
- total_cnt  output  CNT_W  number of resolved branches.
- miss_cnt  output  CNT_W  number of mispredicted branches.

## Operation
- The in-order FIFO holds {addr, taken} entries. It uses read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- Enqueue: pred_valid && pred_ready writes to the tail. With pred_valid while pred_ready=0, the issue is dropped; the upstream stage holds it.
- Full is decided on the current count only. A dequeue in the same cycle does not open a slot at full.
- Resolve: res_valid with count>0 pops the head. It sets upd_valid=1, upd_addr=head.addr, upd_taken=res_taken, total_cnt+=1.
- Miss: if head.taken != res_taken, then mispredict=1, miss_cnt+=1. The whole FIFO is flushed (count=0, rd=wr) at that edge, and any same-cycle enqueue is discarded.
- Hit with a simultaneous enqueue: the pop and the push both occur, and count is unchanged.
- res_valid with count=0: no update, counters unchanged, underflow set. underflow clears only on init.
- init (a synchronous reset, which may arrive mid-operation) has the following effect:
  - It clears the FIFO, all outputs, and the counters to 0 on the next edge.
  - Any pred_valid or res_valid presented in that cycle is ignored.

## Timing
- Resolution on edge N: upd_*, mispredict, and the counter increments are visible after edge N, for exactly one cycle for the strobes.
- Enqueue on edge N: the entry is resolvable from the cycle after edge N; same-cycle enqueue-and-resolve of the same entry is not supported.
- pred_ready is combinational from count and init. It goes 0 in the cycle after a push that fills the queue, and returns to 1 in the cycle after the first pop.
- After a flush, pred_ready=1 in the next cycle.
- Reset values: pred_ready=0 while init=1, and 1 afterwards. upd_valid, upd_addr, upd_taken, mispredict, underflow, total_cnt, and miss_cnt are all 0.

## Configuration
- STAT_SAT_EN defined: total_cnt and miss_cnt saturate at 2^CNT_W−1 and hold there.
- STAT_SAT_EN undefined: both counters wrap modulo 2^CNT_W; for example, with CNT_W=8, the 256th increment gives 0.

## Test plan
- Reset then fill:
  - Stimulus: init for 2 cycles, then 4 pushes (addr 1,2,3,4, taken 1,0,1,0).
  - Required response: pred_ready=0 after the 4th push, and a 5th push (addr 5) is dropped.
- In-order hits:
  - Stimulus: resolve the 4 entries with res_taken 1,0,1,0.
  - Required response: upd_addr 1,2,3,4 on consecutive cycles; mispredict never asserts; total_cnt=4, miss_cnt=0.
- Miss and flush:
  - Stimulus: push addr 1 (T), addr 2 (T), addr 3 (N); resolve with res_taken=0 while pushing addr 6.
  - Required response: mispredict=1 for one cycle, upd_addr=1, upd_taken=0, miss_cnt=1, the queue is empty, and addr 6 is not retained. A following res_valid sets underflow.
- Simultaneous push/pop at occupancy 2:
  - Stimulus: a push and a hit in the same cycle.
  - Required response: count stays 2, and FIFO order is preserved across pointer wrap after 6 such cycles.
- Mid-operation reset:
  - Stimulus: assert init with 3 entries queued and underflow=1.
  - Required response: all outputs and counters read 0 on the next cycle, and pred_ready=1 once init drops.
- Counter overflow with CNT_W=2:
  - Stimulus: 5 hits.
  - Required response: total_cnt=3 when STAT_SAT_EN is defined, and 1 otherwise.
